muldiv_seq: RTL and testbench

- Iterative unsigned multiply/divide sequencer that sits beside the EX-stage ALU.
- Whenever the ALU control decodes an M-type Fun6, the ALU control logic steers the operation here and not to the single-cycle ALU.
- Runs a shift-add or restoring-divide loop of WIDTH iterations and holds the pipeline through busy.
- Returns the result with a one-cycle done pulse, and supports flush from the hazard logic.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/muldiv_seq_step.sv | 37 +++
 rtl/muldiv_seq.sv | 87 ++++++++
 tb/tb_muldiv_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer and the
// ALU control that steers M-type operations to it.
package riscv_pkg;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } md_state_e;

    // M-type Fun6 codes as decoded by the ALU control unit
    localparam logic [5:0] F6_MUL   = 6'b001000;
    localparam logic [5:0] F6_MULHU = 6'b001001;
    localparam logic [5:0] F6_DIVU  = 6'b001010;
    localparam logic [5:0] F6_REMU  = 6'b001011;

    function automatic logic fun6_is_md(input logic [5:0] fun6);
        return (fun6 == F6_MUL) || (fun6 == F6_MULHU) ||
               (fun6 == F6_DIVU) || (fun6 == F6_REMU);
    endfunction

    function automatic logic [1:0] fun6_to_md_op(input logic [5:0] fun6);
        logic [1:0] op;
        case (fun6)
            F6_MULHU: op = MD_MULHU;
            F6_DIVU:  op = MD_DIVU;
            F6_REMU:  op = MD_REMU;
            default:  op = MD_MUL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration of the shift-add multiply or the
// restoring divide; the sequencer feeds it back once per clock.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_rem,
    input  logic [WIDTH-1:0] lo_q,
    input  logic [WIDTH-1:0] opb,
    input  logic             is_div,
    output logic [WIDTH-1:0] hi_rem_nx,
    output logic [WIDTH-1:0] lo_q_nx
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] q_sh;

    always_comb begin
        sum    = {1'b0, hi_rem} + {1'b0, (lo_q[0] ? opb : '0)};
        rem_sh = {hi_rem, lo_q[WIDTH-1]};
        q_sh   = {lo_q[WIDTH-2:0], 1'b0};
        if (is_div) begin
            // remainder after subtraction is below opb, so the low bits suffice
            if (rem_sh >= {1'b0, opb}) begin
                hi_rem_nx = rem_sh[WIDTH-1:0] - opb;
                lo_q_nx   = q_sh | WIDTH'(1);
            end else begin
                hi_rem_nx = rem_sh[WIDTH-1:0];
                lo_q_nx   = q_sh;
            end
        end else begin
            hi_rem_nx = sum[WIDTH:1];
            lo_q_nx   = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer: WIDTH iterations per op,
// busy stalls the pipeline, done pulses once with the result.
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    md_state_e        state, state_n;
    logic [WIDTH-1:0] hi, lo, b;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             accept, div_zero, last;

    md_step #(.WIDTH(WIDTH)) u_step (
        .hi_rem    (hi),
        .lo_q      (lo),
        .opb       (b),
        .is_div    (op[1]),
        .hi_rem_nx (hi_nx),
        .lo_q_nx   (lo_nx)
    );

    assign accept   = (state == S_IDLE) && start && !flush;
    assign div_zero = md_op[1] && (opb == '0);
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = div_zero ? S_DONE : S_RUN;
            S_RUN:   if (flush) state_n = S_IDLE;
                     else if (last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            b      <= '0;
            op     <= MD_MUL;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            if (div_zero) begin
                // RISC-V divide-by-zero: quotient all-ones, remainder = dividend
                result <= (md_op == MD_DIVU) ? '1 : opa;
            end else begin
                hi  <= '0;
                lo  <= opa;
                b   <= opb;
                op  <= md_op;
                cnt <= '0;
            end
        end else if (busy && !flush) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + CNT_W'(1);
            // MULHU and REMU take the upper register, MUL and DIVU the lower
            if (last) result <= op[0] ? hi_nx : lo_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard and cycle-exact
// latency checks for multiply, divide, divide-by-zero, flush and reset.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   md_op;
    logic [W-1:0] opa, opb;
    logic         flush;
    logic         busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .opa    (opa),
        .opb    (opb),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] d);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, d};
        case (op)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (d == 0) ? {W{1'b1}} : a / d;
            default: return (d == 0) ? a : a % d;
        endcase
    endfunction

    // Start one op in cycle 0; expect done in cycle lat and busy for lat-1 cycles.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] d, input logic [W-1:0] exp, input int lat);
        int n;
        int nbusy;
        logic [W-1:0] e;
        md_op = op; opa = a; opb = d; start = 1'b1;
        sb.push_back(exp);
        tick();
        start = 1'b0;
        opa = $urandom; opb = $urandom; md_op = 2'($urandom);
        n = 1; nbusy = 0;
        while (done !== 1'b1 && n < lat + 4) begin
            if (busy === 1'b1) nbusy++;
            tick();
            n++;
        end
        check({tag, "_done_cycle"}, n, lat);
        check({tag, "_busy_cycles"}, nbusy, lat - 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_result"}, result, e);
        tick();
        check({tag, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    initial begin
        int ndone;
        int first_done;
        int second_done;
        logic [W-1:0] e;

        reset = 1'b1; start = 1'b0; md_op = 2'b00; opa = '0; opb = '0; flush = 1'b0;
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        tick();

        do_op("mul_7x6",   2'b00, 7, 6, model(2'b00, 7, 6), 33);
        check("mul_7x6_const", result, 42);
        do_op("mulhu_7x6", 2'b01, 7, 6, model(2'b01, 7, 6), 33);
        check("mulhu_7x6_const", result, 0);
        do_op("mulhu_ff",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mul_ff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        do_op("divu_100_7", 2'b10, 100, 7, 14, 33);
        do_op("remu_100_7", 2'b11, 100, 7, 2, 33);
        do_op("divu_5_9",  2'b10, 5, 9, 0, 33);
        do_op("remu_5_9",  2'b11, 5, 9, 5, 33);
        do_op("divu_big",  2'b10, 32'hF000_0001, 32'h0000_0003, model(2'b10, 32'hF000_0001, 3), 33);
        do_op("remu_big",  2'b11, 32'hFFFF_FFFF, 32'h8000_0001, model(2'b11, 32'hFFFF_FFFF, 32'h8000_0001), 33);
        do_op("divu_z",    2'b10, 32'h1234, 0, 32'hFFFF_FFFF, 1);
        do_op("remu_z",    2'b11, 32'h1234, 0, 32'h1234, 1);

        // flush mid-run: result keeps the previous 42
        do_op("mul_prev", 2'b00, 7, 6, 42, 33);
        md_op = 2'b00; opa = 3; opb = 5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 0);
        check("flush_done", {31'b0, done}, 0);
        check("flush_result", result, 42);
        tick();
        check("flush_no_done", {31'b0, done}, 0);
        do_op("mul_3x5", 2'b00, 3, 5, 15, 33);

        // flush in IDLE wins over start
        md_op = 2'b00; opa = 2; opb = 2; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {31'b0, busy}, 0);
        check("idle_flush_done", {31'b0, done}, 0);

        // async reset mid-divide
        md_op = 2'b10; opa = 1000; opb = 3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_done", {31'b0, done}, 0);
        check("midrst_result", result, 0);
        tick();
        reset = 1'b0;
        tick();

        // start held across an op: exactly one extra acceptance after DONE
        md_op = 2'b00; opa = 9; opb = 11; start = 1'b1;
        sb.push_back(model(2'b00, 9, 11));
        sb.push_back(model(2'b00, 9, 11));
        tick();
        ndone = 0; first_done = -1; second_done = -1;
        for (int c = 1; c <= 70; c++) begin
            if (c > 40) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_done = c;
                else if (ndone == 2) second_done = c;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                check("held_result", result, e);
            end
            if (c < 70) tick();
        end
        start = 1'b0;
        check("held_done_count", ndone, 2);
        check("held_first_done", first_done, 33);
        check("held_second_done", second_done, 67);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
